// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bundle: PC handshake, instruction-memory request/response,
// redirect and the decode-side instruction stream.
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic            pc_enable;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            redirect;
  logic            instr_valid;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            fetch_fault;

  modport master (
    input  pc_in, mem_req_ready, mem_resp_valid, mem_resp_data, redirect, instr_ready,
    output pc_enable, mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
           fetch_fault
  );

  modport slave (
    output pc_in, mem_req_ready, mem_resp_valid, mem_resp_data, redirect, instr_ready,
    input  pc_enable, mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
           fetch_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one outstanding read per PC, results tagged with their PC
// and queued toward decode; redirect squashes buffered and in-flight fetches.
module instruction_fetch_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  instruction_fetch_unit_if.master   ifu
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_RESP, DRAIN} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
  } entry_t;

  state_e                        state_q, state_d;
  entry_t [FIFO_DEPTH-1:0]       buf_q;
  logic   [PW-1:0]               rd_ptr_q, wr_ptr_q;
  logic   [PW:0]                 count_q, count_d;
  logic   [XLEN-1:0]             req_pc_q;
  logic                          fault_q, fault_d;
  logic                          aligned, req_valid, accept, push, pop;

  // A request reserves a FIFO slot up front, so a push can never find it full.
  always_comb begin
    aligned   = (ifu.pc_in[1:0] == 2'b00);
    req_valid = (state_q == IDLE) && !reset && !ifu.redirect && !fault_q && aligned &&
                (count_q < DEPTH_C);
    accept    = req_valid && ifu.mem_req_ready;
    push      = (state_q == WAIT_RESP) && ifu.mem_resp_valid && !ifu.redirect;
    pop       = (count_q != '0) && ifu.instr_ready;

    state_d = state_q;
    fault_d = fault_q;
    count_d = count_q;

    case (state_q)
      IDLE:      if (accept) state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (ifu.mem_resp_valid) state_d = IDLE;
        else if (ifu.redirect)  state_d = DRAIN;
      end
      DRAIN:     if (ifu.mem_resp_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (ifu.redirect)                     fault_d = 1'b0;
    else if (state_q == IDLE && !aligned) fault_d = 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      req_pc_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (accept) req_pc_q <= ifu.pc_in;
      if (ifu.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          buf_q[wr_ptr_q] <= '{pc: req_pc_q, data: ifu.mem_resp_data};
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end
    end
  end

  assign ifu.mem_req_valid = req_valid;
  assign ifu.mem_req_addr  = ifu.pc_in;
  assign ifu.pc_enable     = accept;
  assign ifu.instr_valid   = (count_q != '0);
  assign ifu.instr_data    = buf_q[rd_ptr_q].data;
  assign ifu.instr_pc      = buf_q[rd_ptr_q].pc;
  assign ifu.fetch_fault   = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Fetch unit bench: PC/memory environment plus a queue-based model of the
// instruction stream decode should see.
module tb_instruction_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset;

  instruction_fetch_unit_if #(.XLEN(XLEN)) bus();

  instruction_fetch_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .ifu   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // environment: program counter and instruction memory
  logic [31:0] pc;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          lat;
  bit          spurious;

  // reference model
  ent_t        expq[$];
  bit          m_out, m_squash, m_fault;
  logic [31:0] m_pc;
  logic [31:0] pops[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)   return 32'h0050_0093;
    if (a == 32'h300) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h1234, ~a[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  task automatic step(input bit redir, input logic [31:0] tgt, input bit mrdy, input bit irdy);
    bit   exp_req, resp, idle;
    ent_t e;
    bus.redirect      = redir;
    bus.mem_req_ready = mrdy;
    bus.instr_ready   = irdy;
    bus.pc_in         = pc;
    resp = spurious || (mem_busy && mem_wait == 1);
    bus.mem_resp_valid = resp;
    bus.mem_resp_data  = (mem_busy && resp) ? mem_word(mem_addr) : $urandom;
    #1;
    idle    = !m_out;
    exp_req = !redir && idle && !m_fault && (pc[1:0] == 2'b00) && (expq.size() < DEPTH);
    chk("req_valid", bus.mem_req_valid, exp_req);
    chk("pc_enable", bus.pc_enable, exp_req && mrdy);
    if (exp_req) chk("req_addr", bus.mem_req_addr, pc);
    chk("instr_valid", bus.instr_valid, expq.size() != 0);
    if (expq.size() != 0) begin
      chk("instr_pc", bus.instr_pc, expq[0].pc);
      chk("instr_data", bus.instr_data, expq[0].data);
    end
    chk("fetch_fault", bus.fetch_fault, m_fault);

    // model update for the coming edge
    if (bus.instr_valid && irdy) pops.push_back(bus.instr_pc);
    if (expq.size() != 0 && irdy) void'(expq.pop_front());
    if (resp && m_out) begin
      if (!redir && !m_squash) begin
        e.pc = m_pc; e.data = mem_word(m_pc);
        expq.push_back(e);
      end
      m_out = 0;
    end
    if (redir) begin
      expq.delete();
      if (m_out) m_squash = 1;
      m_fault = 0;
    end else if (idle && pc[1:0] != 2'b00) begin
      m_fault = 1;
    end
    if (exp_req && mrdy) begin
      m_out = 1; m_squash = 0; m_pc = pc;
    end

    // environment update for the coming edge
    if (mem_busy && resp)  mem_busy = 0;
    else if (mem_busy)     mem_wait--;
    if (bus.mem_req_valid && mrdy) begin
      mem_busy = 1; mem_wait = lat; mem_addr = bus.mem_req_addr;
    end
    if (redir)              pc = tgt;
    else if (bus.pc_enable) pc = pc + 32'd4;
    spurious = 0;

    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    reset = 1'b1;
    bus.redirect = 0; bus.mem_req_ready = 0; bus.instr_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.pc_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_instr_data", bus.instr_data, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_pc_enable", bus.pc_enable, 1'b0);
    chk("rst_fetch_fault", bus.fetch_fault, 1'b0);
    reset = 1'b0;
    expq.delete(); pops.delete();
    m_out = 0; m_squash = 0; m_fault = 0; m_pc = '0;
    mem_busy = 0; mem_wait = 0; mem_addr = '0;
    pc = start_pc;
    spurious = 1;  // a stray response right after reset must be ignored
  endtask

  initial begin
    logic [31:0] tgt;

    // basic fetch, response two cycles after accept
    do_reset(32'h0);
    lat = 2;
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("first_pc", bus.instr_pc, 32'h0);
    chk("first_data", bus.instr_data, 32'h0050_0093);
    step(0, 0, 0, 1);

    // streaming from 0x100 with a one-cycle memory
    lat = 1;
    step(1, 32'h100, 0, 1);
    pops.delete();
    repeat (14) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      chk("stream_order", (pops.size() > i) ? pops[i] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * i));

    // backpressure: decode stalled
    step(1, 32'h100, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    chk("bp_head", bus.instr_pc, 32'h100);
    chk("bp_no_req", bus.mem_req_valid, 1'b0);
    pops.delete();
    repeat (10) step(0, 0, 1, 1);
    chk("bp_resume", (pops.size() > 2) ? pops[2] : 32'h0, 32'h108);

    // redirect while a slow response is outstanding
    lat = 3;
    step(1, 32'h300, 0, 1);
    step(0, 0, 1, 1);
    lat = 1;
    step(1, 32'h400, 0, 1);
    pops.delete();
    repeat (10) step(0, 0, 1, 1);
    chk("redir_first", (pops.size() > 0) ? pops[0] : 32'h0, 32'h400);

    // redirect coincident with a response that would fill the FIFO
    step(1, 32'h500, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'h600, 0, 0);
    chk("flush_empty", bus.instr_valid, 1'b0);
    repeat (4) step(0, 0, 1, 1);

    // misaligned PC raises a sticky fault; redirect recovers
    step(1, 32'h102, 0, 1);
    repeat (4) step(0, 0, 1, 1);
    chk("fault_set", bus.fetch_fault, 1'b1);
    step(1, 32'h200, 0, 1);
    pops.delete();
    repeat (6) step(0, 0, 1, 1);
    chk("fault_clr", bus.fetch_fault, 1'b0);
    chk("fault_resume", (pops.size() > 0) ? pops[0] : 32'h0, 32'h200);

    // top of the address space
    step(1, 32'hFFFF_FFF8, 0, 1);
    repeat (8) step(0, 0, 1, 1);

    // randomized traffic
    do_reset({$urandom_range(0, 255), 2'b00});
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
      if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFF0;
      step($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
